vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator: derives a pixel-enable from Clk, runs H/V position counters,
//  emits registered Hsync/Vsync/Active, pixel coordinates and line/frame start strobes.
//  Sits between the system clock and the VRAM reader/pixel drawer; sole owner of raster position.
// PARAMETERS
//  PIX_DIV   2    Clk cycles per pixel (>=1); 2 gives 25 MHz from 50 MHz
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    Hsync active level (0 = active-low)
//  VS_POL    0    Vsync active level (0 = active-low)
//  CNT_W     11   counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  Clk         in   1      system clock
//  Rst_n       in   1      asynchronous reset, active-low
//  Run         in   1      1 = raster advances; 0 = freeze all counters and outputs
//  PixEn       out  1      one-Clk pulse every PIX_DIV cycles while Run=1
//  Hsync       out  1      horizontal sync, level per HS_POL
//  Vsync       out  1      vertical sync, level per VS_POL
//  Active      out  1      1 while presented pixel is inside visible area
//  X           out  CNT_W  presented horizontal position, 0..H_TOTAL-1
//  Y           out  CNT_W  presented vertical position, 0..V_TOTAL-1
//  LineStart   out  1      1 for the PixEn cycle presenting X=0
//  FrameStart  out  1      1 for the PixEn cycle presenting X=0,Y=0
//  FrameCount  out  16     frames started since reset (see CONFIGURATION)
// BEHAVIOUR
//  H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Phase order per axis: ACTIVE, FRONT, SYNC, BACK.
//  Reset (async, Rst_n=0): divider, H, V counters = 0; PixEn=0, Active=0, X=Y=0, LineStart=FrameStart=0,
//   Hsync=~HS_POL, Vsync=~VS_POL, FrameCount=0. Release takes effect on next Clk edge.
//  Divider: counts 0..PIX_DIV-1 while Run=1; PixEn=1 when count=PIX_DIV-1; PIX_DIV=1 -> PixEn=Run.
//  On each PixEn: outputs register decode of current (H,V) counters, then H increments.
//   Latency: counter value -> outputs 1 Clk; first PixEn after reset presents (0,0) with FrameStart=1.
//  Hsync active for H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; Vsync same rule on V.
//  Active = (H<H_ACTIVE)&&(V<V_ACTIVE). X/Y present raw counters, also during blanking.
//  Wrap: H=H_TOTAL-1 -> H=0 and V+1; V=V_TOTAL-1 with H wrap -> V=0 same edge.
//  LineStart/FrameStart: single-Clk pulses (not stretched over PIX_DIV).
//  Run=0: divider, counters, all outputs hold; strobes and PixEn forced 0. Run=1 resumes exactly where frozen.
//  Reset mid-frame: immediate return to reset values; no partial-line completion.
//  All arithmetic unsigned CNT_W; elaboration error if H_TOTAL or V_TOTAL exceeds 2**CNT_W.
// CONFIGURATION
//  VGA_FRAMECNT_EN defined: FrameCount increments (mod 2**16) in the cycle FrameStart is asserted.
//  Not defined: FrameCount tied to 0, no counter registers.
// STRUCTURE
//  Package vga_timing_pkg: typedef enum {PH_ACTIVE,PH_FRONT,PH_SYNC,PH_BACK} vga_phase_t;
//   typedef struct {active,fp,sync,bp} vga_axis_t; constants for default 640x480@60.
//  Sub-module vga_axis_counter (count, wrap, phase decode) instanced twice: H (step=PixEn), V (step=H wrap).
// TESTING
//  Reset: hold Rst_n=0 -> all outputs at reset values, Hsync=Vsync=1 (defaults); release -> first PixEn gives X=0,Y=0,FrameStart=1.
//  Defaults, Run=1: Hsync low exactly 96 pixels (192 Clk) from X=656; Vsync low lines 490-491; FrameStart period 840000 Clk.
//  Small mode PIX_DIV=1, H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=1: H_TOTAL=8, Hsync high X=5,6, frame 48 Clk.
//  Run=0 at X=100,Y=20 for 50 Clk -> outputs hold, PixEn=0; Run=1 -> next PixEn presents X=101.
//  Rst_n pulse at X=300,Y=200 -> outputs reset asynchronously; restart from (0,0).
//  VGA_FRAMECNT_EN, small mode: 65537 frames -> FrameCount=1; without macro FrameCount=0 throughout.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 raster constants for the VGA timing generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } vga_phase_t;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_axis_t;

    localparam int unsigned VGA_PIX_DIV_DEFAULT = 2;
    localparam vga_axis_t   VGA_H_640 = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam vga_axis_t   VGA_V_480 = '{active: 480, fp: 10, sync: 2,  bp: 33};

    function automatic int unsigned axis_total(input vga_axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus ACTIVE/FRONT/SYNC/BACK phase decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W = 11,
    parameter vga_axis_t   AXIS  = VGA_H_640
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output vga_phase_t       phase
);

    localparam int unsigned      TOTAL      = axis_total(AXIS);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FP_START   = CNT_W'(AXIS.active);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(AXIS.active + AXIS.fp);
    localparam logic [CNT_W-1:0] BP_START   = CNT_W'(AXIS.active + AXIS.fp + AXIS.sync);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        if (cnt_q < FP_START) begin
            phase = PH_ACTIVE;
        end else if (cnt_q < SYNC_START) begin
            phase = PH_FRONT;
        end else if (cnt_q < BP_START) begin
            phase = PH_SYNC;
        end else begin
            phase = PH_BACK;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, H/V counters, registered sync/active/position/strobes.
// Optional frame counter enabled by defining VGA_FRAMECNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIX_DIV  = VGA_PIX_DIV_DEFAULT,
    parameter int unsigned H_ACTIVE = VGA_H_640.active,
    parameter int unsigned H_FP     = VGA_H_640.fp,
    parameter int unsigned H_SYNC   = VGA_H_640.sync,
    parameter int unsigned H_BP     = VGA_H_640.bp,
    parameter int unsigned V_ACTIVE = VGA_V_480.active,
    parameter int unsigned V_FP     = VGA_V_480.fp,
    parameter int unsigned V_SYNC   = VGA_V_480.sync,
    parameter int unsigned V_BP     = VGA_V_480.bp,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 11
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Run,
    output logic             PixEn,
    output logic             Hsync,
    output logic             Vsync,
    output logic             Active,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             LineStart,
    output logic             FrameStart,
    output logic [15:0]      FrameCount
);

    localparam vga_axis_t H_AXIS = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam vga_axis_t V_AXIS = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int unsigned      H_TOTAL  = axis_total(H_AXIS);
    localparam int unsigned      V_TOTAL  = axis_total(V_AXIS);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam int unsigned      DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    if (PIX_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: PIX_DIV must be >= 1");
    end
    if (longint'(H_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick, h_wrap;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    vga_phase_t       h_phase, v_phase;

    // tick marks the Clk edge on which the raster steps; PixEn is its registered copy.
    assign tick   = Run && (div_q == DIV_LAST);
    assign h_wrap = tick && (h_cnt == H_LAST);

    always_comb begin
        div_d = div_q;
        if (Run) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    vga_axis_counter #(.CNT_W(CNT_W), .AXIS(H_AXIS)) u_h_axis (
        .clk   (Clk),
        .rst_n (Rst_n),
        .step  (tick),
        .cnt   (h_cnt),
        .phase (h_phase)
    );

    vga_axis_counter #(.CNT_W(CNT_W), .AXIS(V_AXIS)) u_v_axis (
        .clk   (Clk),
        .rst_n (Rst_n),
        .step  (h_wrap),
        .cnt   (v_cnt),
        .phase (v_phase)
    );

    logic             pix_en_q, pix_en_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        pix_en_d      = tick;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (tick) begin
            hsync_d       = (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            vsync_d       = (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            active_d      = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            x_d           = h_cnt;
            y_d           = v_cnt;
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pix_en_q      <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_en_q      <= pix_en_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAMECNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign FrameCount = frame_cnt_q;
`else
    assign FrameCount = '0;
`endif

    assign PixEn      = pix_en_q;
    assign Hsync      = hsync_q;
    assign Vsync      = vsync_q;
    assign Active     = active_q;
    assign X          = x_q;
    assign Y          = y_q;
    assign LineStart  = line_start_q;
    assign FrameStart = frame_start_q;

endmodule
